// File: rtl/display_source.sv
// Four-page display source selector: a debounced push-button steps through
// pages, y shows the selected source (with freeze), and a free-running divider makes the digit-scan clock.
module display_source #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        freeze,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic [15:0] data_c,
  input  logic [15:0] data_d,
  output logic        light_clk,
  output logic [15:0] y,
  output logic [1:0]  page
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          light_q, light_d;
  logic          sync1_q, sync2_q;
  logic          btn_s;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          step_q, step_d;
  logic [1:0]    page_q, page_d;
  logic [15:0]   y_q, y_d;
  logic [15:0]   src_s;

  assign btn_s = sync2_q;

  // Scan divider: wrap and toggle together so each half-period is SCAN_DIV cycles.
  always_comb begin
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      light_d    = ~light_q;
    end else begin
      scan_cnt_d = scan_cnt_q + {{(SW-1){1'b0}}, 1'b1};
      light_d    = light_q;
    end
  end

  // Debounce FSM; step is registered so page moves the cycle after it.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    step_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_s) begin
          state_d   = S_PRESS_WAIT;
          deb_cnt_d = '0;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = S_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = S_PRESSED;
          step_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      S_PRESSED: begin
        if (!btn_s) begin
          state_d   = S_RELEASE_WAIT;
          deb_cnt_d = '0;
        end else begin
          state_d   = S_PRESSED;
        end
      end
      S_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = S_PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = S_IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = S_IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // Source select uses the registered page; y then holds while frozen.
  always_comb begin
    case (page_q)
      2'd0:    src_s = data_a;
      2'd1:    src_s = data_b;
      2'd2:    src_s = data_c;
      2'd3:    src_s = data_d;
      default: src_s = 16'h0000;
    endcase
    if (freeze) begin
      y_d = y_q;
    end else begin
      y_d = src_s;
    end
    page_d = page_q + {1'b0, step_q};
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      light_q    <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= S_IDLE;
      deb_cnt_q  <= '0;
      step_q     <= 1'b0;
      page_q     <= 2'd0;
      y_q        <= 16'h0000;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      light_q    <= light_d;
      sync1_q    <= btn_next;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      step_q     <= step_d;
      page_q     <= page_d;
      y_q        <= y_d;
    end
  end

  assign light_clk = light_q;
  assign y         = y_q;
  assign page      = page_q;

endmodule

// File: tb/tb_display_source.sv
// Directed plus randomized bench for display_source with a run-length
// debounce model, edge-count scan model and page/y reference.
module tb_display_source;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_next;
  logic        freeze;
  logic [15:0] data_a, data_b, data_c, data_d;
  logic        light_clk;
  logic [15:0] y;
  logic [1:0]  page;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          ticks_m;
  logic        h1_m, h2_m;
  logic        level_m;
  int          run_m;
  logic        step_pend_m;
  logic [1:0]  page_m;
  logic [15:0] y_m;

  display_source #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .freeze(freeze),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .light_clk(light_clk), .y(y), .page(page)
  );

  always #5 clk = ~clk;

  function automatic logic light_exp();
    return logic'((ticks_m / SCAN_DIV) % 2);
  endfunction

  function automatic logic [15:0] src_of(input logic [1:0] p);
    logic [15:0] srcs [4];
    srcs[0] = data_a; srcs[1] = data_b; srcs[2] = data_c; srcs[3] = data_d;
    return srcs[p];
  endfunction

  task automatic model_reset();
    ticks_m = 0; h1_m = 1'b0; h2_m = 1'b0; level_m = 1'b0; run_m = 0;
    step_pend_m = 1'b0; page_m = 2'd0; y_m = 16'h0000;
  endtask

  // A level change is accepted once the synchronised button has differed
  // from the accepted level on DEB_CYCLES+1 consecutive edges.
  task automatic model_edge();
    logic bs;
    logic [1:0] next_page;
    if (!reset) begin
      model_reset();
      return;
    end
    bs = h2_m; h2_m = h1_m; h1_m = btn_next;
    next_page = step_pend_m ? page_m + 2'd1 : page_m;
    if (!freeze) y_m = src_of(page_m);
    page_m = next_page;
    step_pend_m = 1'b0;
    if (bs != level_m) begin
      run_m++;
      if (run_m == DEB_CYCLES + 1) begin
        level_m = bs;
        run_m = 0;
        if (bs) step_pend_m = 1'b1;
      end
    end else begin
      run_m = 0;
    end
    ticks_m++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("y", y, y_m);
    check("page", {14'd0, page}, {14'd0, page_m});
    check("light_clk", {15'd0, light_clk}, {15'd0, light_exp()});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int hold, input int gap);
    btn_next = 1'b1; ticks(hold);
    btn_next = 1'b0; ticks(gap);
  endtask

  initial begin
    logic [15:0] y_hold;
    logic [1:0]  page_before;
    int          guard;
    reset = 1'b0; btn_next = 1'b0; freeze = 1'b0;
    data_a = 16'h1234; data_b = 16'hBEEF; data_c = 16'hC0DE; data_d = 16'hD00D;
    model_reset();
    ticks(3);
    check("reset_y", y, 16'h0000);
    check("reset_page", {14'd0, page}, 16'h0000);
    check("reset_light", {15'd0, light_clk}, 16'h0000);

    // Scan: release between edges, then 32 cycles with explicit rise at cycle 4
    #2 reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("scan_phase", {15'd0, light_clk}, {15'd0, logic'((i / 4) % 2)});
    end

    // Clean press
    press(20, 10);
    check("clean_page", {14'd0, page}, 16'h0001);
    check("clean_y", y, 16'hBEEF);

    // Bounce on press and on release
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
    btn_next = 1'b1; ticks(12);
    btn_next = 1'b0; tick(); btn_next = 1'b1; tick(); btn_next = 1'b0; ticks(12);
    check("bounce_page", {14'd0, page}, 16'h0002);
    check("bounce_y", y, 16'hC0DE);

    // Wrap: four presses bring page back around
    for (int k = 0; k < 4; k++) press(8, 8);
    check("wrap_page", {14'd0, page}, 16'h0002);

    // Freeze across a step and a data change
    y_hold = y_m; page_before = page_m;
    freeze = 1'b1;
    press(8, 8);
    data_c = 16'h5A5A; data_d = 16'hA5A5;
    ticks(3);
    check("freeze_y", y, y_hold);
    check("freeze_page", {14'd0, page}, {14'd0, page_before + 2'd1});
    freeze = 1'b0;
    tick();
    check("unfreeze_y", y, 16'hA5A5);

    // Reset mid-debounce while light_clk is high
    guard = 0;
    while (light_exp() != 1'b1 && guard < 16) begin tick(); guard++; end
    check("light_high_before_reset", {15'd0, light_clk}, 16'h0001);
    btn_next = 1'b1; tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_y", y, 16'h0000);
    check("async_page", {14'd0, page}, 16'h0000);
    check("async_light", {15'd0, light_clk}, 16'h0000);
    btn_next = 1'b0;
    ticks(2);
    #2 reset = 1'b1;
    ticks(10);
    check("post_reset_page", {14'd0, page}, 16'h0000);

    // Randomized bursts
    for (int b = 0; b < 60; b++) begin
      btn_next = 1'($urandom_range(0, 1));
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        data_a = 16'($urandom); data_b = 16'($urandom);
        data_c = 16'($urandom); data_d = 16'($urandom);
      end
      ticks($urandom_range(1, 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/display_source.md
DISPLAY_SOURCE -- requirements
Module: display_source

Interface
REQ-001 Parameter SCAN_DIV, default 50000, half-period of light_clk in clk cycles (legal range >= 2).
REQ-002 Parameter DEB_CYCLES, default 1000000, number of stable clk cycles needed to accept a button level change (legal range >= 2).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset: 0 resets immediately, release is sampled on clk.
REQ-005 btn_next  input  1  raw, asynchronous, bouncing push-button; 1 = pressed.
REQ-006 freeze  input  1  1 = hold the current y value.
REQ-007 data_a, data_b, data_c, data_d  input  16 each  display sources for pages 0, 1, 2, 3.
REQ-008 light_clk  output  1  registered digit-scan clock for the 4-digit seven-segment driver.
REQ-009 y  output  16  registered value to display.
REQ-010 page  output  2  registered index of the currently selected source.

Function
REQ-011 Scan divider: counter runs 0..SCAN_DIV-1.
- At SCAN_DIV-1 it wraps to 0 and light_clk toggles in the same cycle.
- light_clk period is exactly 2*SCAN_DIV clk cycles, 50% duty.
- The divider free-runs regardless of freeze or button activity.
REQ-012 btn_next passes through a 2-flop synchroniser; only its output (btn_s) feeds the debouncer.
REQ-013 Debounce FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; shared counter deb_cnt.
REQ-014 IDLE:
- btn_s=1 -> PRESS_WAIT, deb_cnt=0.
- Otherwise stay in IDLE.
REQ-015 PRESS_WAIT:
- btn_s=0 -> IDLE.
- Else deb_cnt==DEB_CYCLES-1 -> PRESSED and assert internal step for exactly one cycle.
- Else deb_cnt increments.
REQ-016 PRESSED:
- btn_s=0 -> RELEASE_WAIT, deb_cnt=0.
- Otherwise stay in PRESSED; no further step while held, so there is no auto-repeat.
REQ-017 RELEASE_WAIT:
- btn_s=1 -> PRESSED, with no step.
- Else deb_cnt==DEB_CYCLES-1 -> IDLE.
- Else deb_cnt increments.
REQ-018 One press yields exactly one step, regardless of bounce shorter than DEB_CYCLES on either edge.
REQ-019 page increments by 1 on the cycle after step; 2-bit modulo arithmetic, so 3 wraps to 0.
REQ-020 y update, each cycle:
- freeze=0: y <= source selected by the current registered page (0=a, 1=b, 2=c, 3=d).
- freeze=1: y holds.
REQ-021 Latency:
- A source change appears on y 1 cycle later.
- A step appears on y 2 cycles after step (page, then y).
REQ-022 Simultaneous step and freeze=1: page still advances and y holds. When freeze deasserts, y loads the new page's source on the next edge.
REQ-023 Release of freeze: the first clk edge with freeze=0 loads y; there is no extra delay.
REQ-024 deb_cnt width is sized to hold DEB_CYCLES-1 and the scan counter to hold SCAN_DIV-1; neither saturates or overflows in legal use.

Reset
REQ-025 While reset=0, asynchronously:
- light_clk=0, y=16'h0000, page=0.
- FSM=IDLE, deb_cnt=0, scan counter=0, synchroniser flops=0.
REQ-026 Reset asserted mid-debounce or mid-scan aborts the operation with no step and no light_clk glitch beyond the forced 0.
REQ-027 After reset release, the first light_clk rising edge occurs exactly SCAN_DIV cycles later.

Verification
Bench parameters for all scenarios: SCAN_DIV=4, DEB_CYCLES=3.
REQ-028 Scan: release reset, run 32 cycles -> light_clk toggles every 4 cycles, first rise at cycle 4, 4 full periods.
REQ-029 Clean press: data_a=16'h1234, data_b=16'hBEEF, freeze=0, btn_next held 1 for 20 cycles -> exactly one step; page 0->1; y 16'h1234 -> 16'hBEEF 2 cycles after step; no further change while held.
REQ-030 Bounce: btn_next toggles 1,0,1,0 on consecutive cycles then settles at 1 -> single step only after 3 stable synchronised cycles; release with 2-cycle bounce -> no extra step.
REQ-031 Wrap: 4 clean presses from page 0 -> page sequence 1,2,3,0; y tracks data_b, data_c, data_d, data_a.
REQ-032 Freeze: y=16'h1234, assert freeze, press once, change data_a -> page=1, y stays 16'h1234; deassert freeze -> y = data_b on the next edge.
REQ-033 Reset mid-operation: assert reset during PRESS_WAIT with light_clk=1 -> all outputs 0 immediately, no step after release, page stays 0.
